// File: rtl/pipes_pkg.sv
// Shared pipeline payload types and defaults for the pipe stage register slice.
// The stage itself is payload-agnostic; these types size its WIDTH at call sites.
package pipes_pkg;

    localparam int unsigned STALL_CNT_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [26:0] ctrl;
    } decode_data_t;

    localparam int unsigned FETCH_DATA_W  = $bits(fetch_data_t);
    localparam int unsigned DECODE_DATA_W = $bits(decode_data_t);

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional skid entry, freeze/flush control
// and a saturating count of cycles in which upstream was blocked.
module pipe_stage_reg
    import pipes_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_DATA_W,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             freeze,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             flush_pend_q, flush_pend_d;
    logic             ready_w;
    logic             xfer_in;
    logic             xfer_out;
    logic             flush_now;
    logic             stall;

    // A flush seen under freeze is parked and applied on the first unfrozen cycle.
    assign flush_now    = !freeze && (flush || flush_pend_q);
    assign flush_pend_d = freeze ? (flush_pend_q || flush) : 1'b0;
    assign xfer_in      = in_valid && ready_w;
    assign xfer_out     = main_valid_q && out_ready && !freeze;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (!freeze) begin
            if (flush_now) begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
            end else if (!main_valid_q || xfer_out) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                end else if (xfer_in) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end else begin
                    main_valid_d = 1'b0;
                    main_data_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic             skid_valid_d;
            logic [WIDTH-1:0] skid_data_d;

            // Skid only fills while main is held; it drains into main on any free slot.
            always_comb begin
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (!freeze) begin
                    if (flush_now || !main_valid_q || xfer_out) begin
                        skid_valid_d = 1'b0;
                        skid_data_d  = '0;
                    end else if (xfer_in) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= '0;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                end
            end

            assign ready_w = !reset && !freeze && !skid_valid_q;
        end else begin : g_no_skid
            assign skid_valid_q = 1'b0;
            assign skid_data_q  = '0;
            assign ready_w      = !reset && !freeze && (!main_valid_q || out_ready);
        end
    endgenerate

    assign stall = in_valid && !ready_w;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (stall),
        .clear(1'b0),
        .count(stall_cnt)
    );

    assign in_ready  = ready_w;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (SKID=1, CNT_W=4): stimulus queues expected
// beats, a negedge monitor pops and compares every delivered beat.
module tb_pipe_stage_reg;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int unsigned   n_vec = 0;
    int unsigned   n_bad = 0;
    logic [W-1:0]  exp_q[$];

    pipe_stage_reg #(
        .WIDTH(W),
        .SKID (1),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .freeze   (freeze),
        .flush    (flush),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor: every beat leaving the stage must be the oldest expected beat.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset) begin
            if (out_valid && out_ready && !freeze) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("fifo_order", 32'(out_data), 32'(e));
                end
            end else if (!out_valid) begin
                chk("bubble_zero", 32'(out_data), 32'h0);
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        in_valid = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single beat, latency one cycle
        step();
        in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
        settle();
        chk("t1_in_ready", 32'(in_ready), 32'h1);
        exp_q.push_back(16'h00A5);
        step();
        in_valid = 1'b0;
        settle();
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_out_data", 32'(out_data), 32'h00A5);
        chk("t1_occupancy", 32'(occupancy), 32'h1);
        step();
        chk("t1_drained", 32'(occupancy), 32'h0);

        // Back-pressure fills main and skid, then drains in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0001;
        settle();
        chk("t2_rdy1", 32'(in_ready), 32'h1);
        exp_q.push_back(16'h0001);
        step();
        in_data = 16'h0002;
        settle();
        chk("t2_rdy2", 32'(in_ready), 32'h1);
        chk("t2_occ1", 32'(occupancy), 32'h1);
        exp_q.push_back(16'h0002);
        step();
        in_data = 16'h0003;
        settle();
        chk("t2_full_rdy", 32'(in_ready), 32'h0);
        chk("t2_occ2", 32'(occupancy), 32'h2);
        chk("t2_head", 32'(out_data), 32'h0001);
        step();
        chk("t2_stall1", 32'(stall_cnt), 32'h1);
        out_ready = 1'b1;
        settle();
        chk("t2_still_full", 32'(in_ready), 32'h0);
        step();
        chk("t2_stall2", 32'(stall_cnt), 32'h2);
        chk("t2_rdy_again", 32'(in_ready), 32'h1);
        chk("t2_occ_after", 32'(occupancy), 32'h1);
        exp_q.push_back(16'h0003);
        step();
        in_valid = 1'b0;
        settle();
        chk("t2_pass_occ", 32'(occupancy), 32'h1);
        chk("t2_pass_data", 32'(out_data), 32'h0003);
        step();
        chk("t2_empty", 32'(occupancy), 32'h0);

        // Freeze + flush while full: hold, then pending flush empties the stage
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0011;
        exp_q.push_back(16'h0011);
        step();
        in_data = 16'h0022;
        exp_q.push_back(16'h0022);
        step();
        in_valid = 1'b0;
        freeze = 1'b1; flush = 1'b1; out_ready = 1'b1;
        settle();
        chk("t3_occ_full", 32'(occupancy), 32'h2);
        chk("t3_frz_rdy", 32'(in_ready), 32'h0);
        step();
        flush = 1'b0;
        settle();
        chk("t3_hold_occ", 32'(occupancy), 32'h2);
        chk("t3_hold_vld", 32'(out_valid), 32'h1);
        chk("t3_hold_data", 32'(out_data), 32'h0011);
        step();
        chk("t3_hold_data2", 32'(out_data), 32'h0011);
        freeze = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        step();
        chk("t3_fl_vld", 32'(out_valid), 32'h0);
        chk("t3_fl_data", 32'(out_data), 32'h0);
        chk("t3_fl_occ", 32'(occupancy), 32'h0);

        // Beat accepted with flush is discarded; next beat flows normally
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h0077; flush = 1'b1;
        settle();
        chk("t4_rdy_flush", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0; flush = 1'b0;
        settle();
        chk("t4_no77_vld", 32'(out_valid), 32'h0);
        chk("t4_no77_occ", 32'(occupancy), 32'h0);
        in_valid = 1'b1; in_data = 16'h005A;
        exp_q.push_back(16'h005A);
        step();
        in_valid = 1'b0;
        settle();
        chk("t4_next_data", 32'(out_data), 32'h005A);
        step();

        // Stall counter saturates under a long freeze
        freeze = 1'b1; in_valid = 1'b1; in_data = 16'h0099;
        for (int unsigned i = 0; i < 5; i++) step();
        chk("t5_cnt7", 32'(stall_cnt), 32'h7);
        for (int unsigned i = 5; i < 20; i++) step();
        chk("t5_cnt_sat", 32'(stall_cnt), 32'hF);
        step();
        chk("t5_cnt_hold", 32'(stall_cnt), 32'hF);
        freeze = 1'b0; in_valid = 1'b0;
        step();
        chk("t5_idle_occ", 32'(occupancy), 32'h0);

        // Asynchronous reset between edges while full, then clean restart
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0031;
        exp_q.push_back(16'h0031);
        step();
        in_data = 16'h0032;
        exp_q.push_back(16'h0032);
        step();
        in_valid = 1'b0;
        settle();
        chk("t6_occ_full", 32'(occupancy), 32'h2);
        @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_vld", 32'(out_valid), 32'h0);
        chk("t6_rst_data", 32'(out_data), 32'h0);
        chk("t6_rst_occ", 32'(occupancy), 32'h0);
        chk("t6_rst_rdy", 32'(in_ready), 32'h0);
        chk("t6_rst_cnt", 32'(stall_cnt), 32'h0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h0044;
        settle();
        chk("t6_restart_rdy", 32'(in_ready), 32'h1);
        exp_q.push_back(16'h0044);
        step();
        in_valid = 1'b0;
        settle();
        chk("t6_restart_data", 32'(out_data), 32'h0044);
        chk("t6_restart_occ", 32'(occupancy), 32'h1);
        step();
        step();
        chk("end_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
